// File: rtl/mem_port_initiator.sv
// Load/store initiator driving the bMEMPortDualIO memory bundle, one request in flight at a time.
// Define MEM_PORT_INITIATOR_RMW_EN to merge sub-dword stores into a previously read dword.
module mem_port_initiator #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iReqValid,
  output logic        oReqReady,
  input  logic        iReqWr,
  input  logic [63:0] iReqAddr,
  input  logic [63:0] iReqWrData,
  input  logic [1:0]  iReqSize,
  input  logic        iReqSigned,
  output logic        oRespValid,
  output logic [63:0] oRespData,
  output logic        oRespErr,
  output logic        bMEMPortDualIO_oRdEn,
  output logic        bMEMPortDualIO_oWrEn,
  output logic [63:0] bMEMPortDualIO_oAddr,
  output logic [63:0] bMEMPortDualIO_oWrData,
  output logic [9:0]  bMEMPortDualIO_oWrByt,
  input  logic [63:0] bMEMPortDualIO_iRdData
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(RD_LAT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] data_q, data_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;

  logic        rd_en_q, rd_en_d;
  logic        wr_en_q, wr_en_d;
  logic [63:0] mem_addr_q, mem_addr_d;
  logic [63:0] wr_data_q, wr_data_d;
  logic [9:0]  wr_byt_q, wr_byt_d;
  logic        resp_valid_q, resp_valid_d;
  logic [63:0] resp_data_q, resp_data_d;
  logic        resp_err_q, resp_err_d;

  logic        store_needs_read;
  logic [7:0]  lane_base;
  logic [7:0]  byte_en;
  logic [63:0] merge_mask;
  logic [63:0] merge_data;

  function automatic logic [63:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 64'h0000_0000_0000_00FF;
      2'd1:    return 64'h0000_0000_0000_FFFF;
      2'd2:    return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] off, input logic [1:0] size);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return off[0];
      2'd2:    return |off[1:0];
      default: return |off;
    endcase
  endfunction

  function automatic logic [63:0] load_extract(input logic [63:0] rd, input logic [2:0] off,
                                               input logic [1:0] size, input logic sgn);
    logic [63:0] sh;
    sh = rd >> {off, 3'b000};
    case (size)
      2'd0:    return {{56{sgn & sh[7]}}, sh[7:0]};
      2'd1:    return {{48{sgn & sh[15]}}, sh[15:0]};
      2'd2:    return {{32{sgn & sh[31]}}, sh[31:0]};
      default: return sh;
    endcase
  endfunction

`ifdef MEM_PORT_INITIATOR_RMW_EN
  assign store_needs_read = (iReqSize != 2'd3);
`else
  assign store_needs_read = 1'b0;
`endif

  // Byte-lane mask of the captured access, expanded to bits for the merge.
  always_comb begin
    case (size_q)
      2'd0:    lane_base = 8'h01;
      2'd1:    lane_base = 8'h03;
      2'd2:    lane_base = 8'h0F;
      default: lane_base = 8'hFF;
    endcase
    byte_en = lane_base << addr_q[2:0];
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      assign merge_mask[gi*8 +: 8] = {8{byte_en[gi]}};
    end
  endgenerate

  assign merge_data = (bMEMPortDualIO_iRdData & ~merge_mask)
                    | ((data_q << {addr_q[2:0], 3'b000}) & merge_mask);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    data_d       = data_q;
    size_d       = size_q;
    sgn_d        = sgn_q;
    rd_en_d      = 1'b0;
    wr_en_d      = 1'b0;
    mem_addr_d   = '0;
    wr_data_d    = '0;
    wr_byt_d     = '0;
    resp_valid_d = 1'b0;
    resp_data_d  = '0;
    resp_err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (iReqValid) begin
          wr_d   = iReqWr;
          addr_d = iReqAddr;
          data_d = iReqWrData;
          size_d = iReqSize;
          sgn_d  = iReqSigned;
          if (misaligned(iReqAddr[2:0], iReqSize)) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (!iReqWr || store_needs_read) begin
            state_d    = S_RD;
            cnt_d      = CNT_INIT;
            rd_en_d    = 1'b1;
            mem_addr_d = {iReqAddr[63:3], 3'b000};
          end else begin
            // Direct write: dword stores, or any store when the responder places lanes.
            state_d    = S_WR;
            wr_en_d    = 1'b1;
            mem_addr_d = iReqAddr;
            wr_data_d  = iReqWrData & size_mask(iReqSize);
            wr_byt_d   = 10'(iReqSize) + 10'd1;
          end
        end
      end
      S_RD: begin
        if (cnt_q == 4'd0) begin
          if (wr_q) begin
            state_d    = S_WR;
            wr_en_d    = 1'b1;
            mem_addr_d = {addr_q[63:3], 3'b000};
            wr_data_d  = merge_data;
            wr_byt_d   = 10'd4;
          end else begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_data_d  = load_extract(bMEMPortDualIO_iRdData, addr_q[2:0], size_q, sgn_q);
          end
        end else begin
          cnt_d      = cnt_q - 4'd1;
          rd_en_d    = 1'b1;
          mem_addr_d = {addr_q[63:3], 3'b000};
        end
      end
      S_WR: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      size_q       <= '0;
      sgn_q        <= 1'b0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      mem_addr_q   <= '0;
      wr_data_q    <= '0;
      wr_byt_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      size_q       <= size_d;
      sgn_q        <= sgn_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      mem_addr_q   <= mem_addr_d;
      wr_data_q    <= wr_data_d;
      wr_byt_q     <= wr_byt_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign oReqReady              = (state_q == S_IDLE) && !iReset;
  assign oRespValid             = resp_valid_q;
  assign oRespData              = resp_data_q;
  assign oRespErr               = resp_err_q;
  assign bMEMPortDualIO_oRdEn   = rd_en_q;
  assign bMEMPortDualIO_oWrEn   = wr_en_q;
  assign bMEMPortDualIO_oAddr   = mem_addr_q;
  assign bMEMPortDualIO_oWrData = wr_data_q;
  assign bMEMPortDualIO_oWrByt  = wr_byt_q;

endmodule

// File: doc/mem_port_initiator.md
# mem_port_initiator

Load/store initiator for the multi-cycle core's data path. It accepts one load or store request at a time from the execute stage and drives the dual-port memory bundle (`bMEMPortDualIO_*`) as its master. It handles several jobs around each access:
- alignment checking;
- byte-lane extraction and sign extension for loads;
- read-merge-write for sub-dword stores;
- a one-cycle response pulse back to the core.

## Interface
- `RD_LAT`, default 1, cycles `oRdEn` is held before read data is sampled. Legal range 1..15.
- `iClock` in 1, core clock.
- `iReset` in 1, reset; synchronous, active-high.
- `iReqValid` in 1, request valid.
- `oReqReady` out 1, high only in IDLE and only when `iReset` is 0.
- `iReqWr` in 1, 1 = store, 0 = load.
- `iReqAddr` in 64, byte address.
- `iReqWrData` in 64, store data, right-aligned.
- `iReqSize` in 2, access size: 0 = byte, 1 = half, 2 = word, 3 = dword.
- `iReqSigned` in 1, sign-extend the load result; ignored for stores and dword loads.
- `oRespValid` out 1, one-cycle completion pulse.
- `oRespData` out 64, load result; 0 for stores and errors.
- `oRespErr` out 1, misaligned request; valid with `oRespValid`.
- `bMEMPortDualIO_oRdEn` out 1, memory read enable.
- `bMEMPortDualIO_oWrEn` out 1, memory write enable.
- `bMEMPortDualIO_oAddr` out 64, memory address.
- `bMEMPortDualIO_oWrData` out 64, memory write data.
- `bMEMPortDualIO_oWrByt` out 10, write size code: 1 = byte, 2 = half, 3 = word, 4 = dword.
- `bMEMPortDualIO_iRdData` in 64, memory read data.

## Operation
- **States:** IDLE, RD, WR, RESP. All state and outputs are registered.
- **Acceptance:** a request is accepted on a cycle with `iReqValid & oReqReady`. On acceptance the block captures `wr`, `addr`, `data`, `size` and `signed`. `iReqValid` outside IDLE is ignored.
- **Alignment:** a request is misaligned when `addr[2:0]` is not a multiple of `1<<size`. A misaligned request goes IDLE→RESP with `oRespErr=1` and no memory access.
- **IDLE → RD:** taken for loads, and for stores with `size<3` when RMW is compiled in.
- **IDLE → WR:** taken for all other stores.
- **RD:**
  - `oRdEn=1` and `oAddr={addr[63:3],3'b0}`.
  - A 4-bit counter loads `RD_LAT-1` and decrements each cycle.
  - At the edge ending the cycle where the counter is 0, `iRdData` is latched into `buf`. The next state is RESP for loads and WR for stores.
- **WR:**
  - `oWrEn=1` for exactly one cycle; then the next state is RESP.
  - With RMW, let `m` = the mask of `(1<<size)` bytes at byte offset `off=addr[2:0]`:
    - `oWrData = (buf & ~m) | ((data << 8*off) & m)`
    - `oWrByt = 4`
    - `oAddr` is the aligned address.
  - Full dword stores use `oWrData=data`, `oWrByt=4` and the aligned address.
- **RESP:** `oRespValid=1` for one cycle, then IDLE. The response is not back-pressured.
- **Load result:**
  - `sh = buf >> 8*off`, truncated to `8<<size` bits.
  - Zero-extended, or sign-extended from bit `(8<<size)-1` when `signed` is set.
- **Reset values:** all outputs are 0 and the state is IDLE.
- **Reset mid-operation:** `iReset` high in any state forces IDLE at the next edge. It also deasserts `oRdEn`/`oWrEn`, suppresses any pending response, and discards `buf`.
- `oRdEn` and `oWrEn` are never high in the same cycle.

## Timing
- Acceptance occurs at cycle T.
- Load: `oRdEn` is high T+1..T+RD_LAT and `oRespValid` is high at T+RD_LAT+1. With `RD_LAT=1` the response is at T+2.
- Dword store: `oWrEn` at T+1, `oRespValid` at T+2.
- Sub-dword store with RMW: `oRdEn` T+1..T+RD_LAT, `oWrEn` at T+RD_LAT+1, `oRespValid` at T+RD_LAT+2.
- Misaligned request: `oRespValid` and `oRespErr` at T+1.
- Back-to-back requests: `oReqReady` returns high the cycle after RESP. Minimum throughput is one request per 3 cycles.

## Configuration
- `MEM_PORT_INITIATOR_RMW_EN`
  - **Defined:** sub-dword stores perform read-merge-write as above and always write with `oWrByt=4`.
  - **Undefined:** every store goes IDLE→WR with no read. In that case:
    - `oAddr` is the unmodified byte address.
    - `oWrData` is `data` zero-extended above `8<<size` bits.
    - `oWrByt` is `size+1`.
    - The responder performs lane placement.
  - Load behaviour is identical in both builds.

## Test plan
- **Signed byte load:** memory dword at 0x80000000 = 0x1122334455667788; signed byte load at 0x80000000, `RD_LAT=1`. Required: `oRdEn` at T+1 with `oAddr` 0x80000000; at T+2, `oRespData` = 0xFFFFFFFFFFFFFF88 and `oRespErr` = 0.
- **Unsigned half load:** same memory; unsigned half load at 0x80000006. Required: `oRespData` = 0x0000000000001122 at T+2.
- **RMW byte store:** RMW build; byte store of 0xAB at 0x80000001. Required: `oRdEn` at T+1; at T+2, `oWrEn` with `oWrData` 0x112233445566AB88, `oWrByt` 4 and `oAddr` 0x80000000; `oRespValid` at T+3.
- **Misaligned load:** word load at 0x80000002. Required: `oRespValid` and `oRespErr` at T+1, `oRespData` = 0, and no `oRdEn`/`oWrEn` at any cycle.
- **Longer read latency:** `RD_LAT=3`, dword load at 0x80000000. Required: `oRdEn` high T+1..T+3; `oRespValid` at T+4 with `oRespData` 0x1122334455667788.
- **Reset mid-access:** `iReset` pulsed during RD. Required: `oRdEn` = 0 the next cycle, no `oRespValid`, and `oReqReady` = 1 on the first cycle after `iReset` falls.
